aes_inv_sub_shift: RTL
======================

# aes_inv_sub_shift

Byte-serial AES inverse round front end: accepts a 128-bit cipher state, applies InvShiftRows and InvSubBytes, and returns the transformed state over a valid/ready handshake. It sits in the decryption datapath ahead of AddRoundKey/InvMixColumns and is the inverse counterpart of the forward S-box substitution used by the encryption path. Throughput and area are traded through the number of parallel inverse S-box lanes.

## Interface
- LANES, default 1: inverse S-box instances used per cycle; legal values 1, 2, 4, 8, 16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  block can accept in_state.
- in_state  input  128  input state; byte i = in_state[127-8i -: 8], i = r + 4c (row r, column c).
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  128  result, same byte ordering.
- busy  output  1  high in RUN or DONE.

## Operation
- Function: out byte (r,c) = InvSbox(in byte (r, (c - r) mod 4)); InvSbox is the standard FIPS-197 inverse table (InvSbox(63)=00, InvSbox(00)=52, InvSbox(16)=FF).
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_state into src register, clear cnt, go RUN.
- RUN: in_ready=0. Each cycle computes out bytes cnt*LANES .. cnt*LANES+LANES-1 from src through LANES inverse S-box lanes, writes them into dst register. cnt increments; when cnt = 16/LANES-1, go DONE. cnt width = clog2(16/LANES), minimum 1 bit; wraps to 0 on leaving RUN.
- DONE: out_valid=1, out_state=dst, held stable until out_ready. On out_valid&&out_ready: if in_valid also high, capture new in_state and go RUN directly (in_ready = out_ready in DONE); else go IDLE.
- in_ready never asserted while RUN; in_state ignored outside acceptance.
- dst bytes not yet written in RUN retain prior values; out_state only meaningful when out_valid=1.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, out_state=128'h0, src=0, cnt=0.
- Latency: acceptance edge E0; out_valid high in the cycle after edge E(16/LANES) (LANES=1: 16 edges; LANES=16: 1 edge).
- Throughput with out_ready held high: one state per 16/LANES+1 cycles (DONE cycle overlaps next acceptance).
- S-box lanes are combinational between src/cnt and dst; no extra pipeline stage.
- Reset mid-RUN or mid-DONE: immediate return to IDLE, in-flight state discarded, outputs to reset values; no output handshake completes.
- out_ready high in IDLE/RUN has no effect.

## Structure
- Shared package aes_pkg: AES_STATE_W=128, AES_BYTE_W=8, state enum {IDLE, RUN, DONE}, function for byte-slice index i -> bit offset, function for InvShiftRows source index.
- One sub-module: aes_inv_sbox (8-bit combinational inverse table, case-based), instantiated LANES times.

## Test plan
- Reset, then in_state=128'h63636363_63636363_63636363_63636363, out_ready=1 -> out_state=128'h0 after 16 edges (LANES=1), out_valid one cycle.
- in_state=128'h0 -> out_state=128'h52525252_52525252_52525252_52525252.
- in_state=128'h637c777b_f26b6fc5_3001672b_fed7ab76 -> out_state=128'h000d0a07_04010e0b_08050 20f_0c090603 with spaces removed (128'h000d0a0704010e0b08050 20f0c090603 = 000d0a07 04010e0b 0805020f 0c090603), checked for LANES=1,4,16.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_state stable, in_ready=0; then out_ready=1 with in_valid=1 -> next state accepted same edge, next out_valid 16 edges later.
- Assert rst_n=0 at RUN cycle 7 -> out_valid=0, in_ready=1 immediately; new input afterwards yields correct result.
- Exhaustive: 16 states covering input bytes 00..FF -> every output byte matches reference inverse table, including InvSbox(16)=FF.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the byte-serial inverse-round front end.
// Holds the state/byte widths, the FSM state type and the byte-index helpers.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NBYTES  = AES_STATE_W / AES_BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Byte i lives in state[127-8i -: 8]; return the LSB position of that slice.
  function automatic int unsigned byte_lsb(input int unsigned i);
    return AES_STATE_W - AES_BYTE_W * (i + 1);
  endfunction

  // InvShiftRows: output byte (r,c) takes input byte (r, (c-r) mod 4), i = r + 4c.
  function automatic int unsigned inv_shift_src(input int unsigned i);
    int unsigned r;
    int unsigned c;
    r = i % 4;
    c = i / 4;
    return r + 4 * ((c + 4 - r) % 4);
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box (FIPS-197 InvSbox table).
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] in_byte,
  output logic [AES_BYTE_W-1:0] out_byte
);

  // Table lookup, eight entries per line in row-major order.
  always_comb begin
    out_byte = 8'h00;
    case (in_byte)
      8'h00: out_byte = 8'h52; 8'h01: out_byte = 8'h09; 8'h02: out_byte = 8'h6a; 8'h03: out_byte = 8'hd5; 8'h04: out_byte = 8'h30; 8'h05: out_byte = 8'h36; 8'h06: out_byte = 8'ha5; 8'h07: out_byte = 8'h38;
      8'h08: out_byte = 8'hbf; 8'h09: out_byte = 8'h40; 8'h0a: out_byte = 8'ha3; 8'h0b: out_byte = 8'h9e; 8'h0c: out_byte = 8'h81; 8'h0d: out_byte = 8'hf3; 8'h0e: out_byte = 8'hd7; 8'h0f: out_byte = 8'hfb;
      8'h10: out_byte = 8'h7c; 8'h11: out_byte = 8'he3; 8'h12: out_byte = 8'h39; 8'h13: out_byte = 8'h82; 8'h14: out_byte = 8'h9b; 8'h15: out_byte = 8'h2f; 8'h16: out_byte = 8'hff; 8'h17: out_byte = 8'h87;
      8'h18: out_byte = 8'h34; 8'h19: out_byte = 8'h8e; 8'h1a: out_byte = 8'h43; 8'h1b: out_byte = 8'h44; 8'h1c: out_byte = 8'hc4; 8'h1d: out_byte = 8'hde; 8'h1e: out_byte = 8'he9; 8'h1f: out_byte = 8'hcb;
      8'h20: out_byte = 8'h54; 8'h21: out_byte = 8'h7b; 8'h22: out_byte = 8'h94; 8'h23: out_byte = 8'h32; 8'h24: out_byte = 8'ha6; 8'h25: out_byte = 8'hc2; 8'h26: out_byte = 8'h23; 8'h27: out_byte = 8'h3d;
      8'h28: out_byte = 8'hee; 8'h29: out_byte = 8'h4c; 8'h2a: out_byte = 8'h95; 8'h2b: out_byte = 8'h0b; 8'h2c: out_byte = 8'h42; 8'h2d: out_byte = 8'hfa; 8'h2e: out_byte = 8'hc3; 8'h2f: out_byte = 8'h4e;
      8'h30: out_byte = 8'h08; 8'h31: out_byte = 8'h2e; 8'h32: out_byte = 8'ha1; 8'h33: out_byte = 8'h66; 8'h34: out_byte = 8'h28; 8'h35: out_byte = 8'hd9; 8'h36: out_byte = 8'h24; 8'h37: out_byte = 8'hb2;
      8'h38: out_byte = 8'h76; 8'h39: out_byte = 8'h5b; 8'h3a: out_byte = 8'ha2; 8'h3b: out_byte = 8'h49; 8'h3c: out_byte = 8'h6d; 8'h3d: out_byte = 8'h8b; 8'h3e: out_byte = 8'hd1; 8'h3f: out_byte = 8'h25;
      8'h40: out_byte = 8'h72; 8'h41: out_byte = 8'hf8; 8'h42: out_byte = 8'hf6; 8'h43: out_byte = 8'h64; 8'h44: out_byte = 8'h86; 8'h45: out_byte = 8'h68; 8'h46: out_byte = 8'h98; 8'h47: out_byte = 8'h16;
      8'h48: out_byte = 8'hd4; 8'h49: out_byte = 8'ha4; 8'h4a: out_byte = 8'h5c; 8'h4b: out_byte = 8'hcc; 8'h4c: out_byte = 8'h5d; 8'h4d: out_byte = 8'h65; 8'h4e: out_byte = 8'hb6; 8'h4f: out_byte = 8'h92;
      8'h50: out_byte = 8'h6c; 8'h51: out_byte = 8'h70; 8'h52: out_byte = 8'h48; 8'h53: out_byte = 8'h50; 8'h54: out_byte = 8'hfd; 8'h55: out_byte = 8'hed; 8'h56: out_byte = 8'hb9; 8'h57: out_byte = 8'hda;
      8'h58: out_byte = 8'h5e; 8'h59: out_byte = 8'h15; 8'h5a: out_byte = 8'h46; 8'h5b: out_byte = 8'h57; 8'h5c: out_byte = 8'ha7; 8'h5d: out_byte = 8'h8d; 8'h5e: out_byte = 8'h9d; 8'h5f: out_byte = 8'h84;
      8'h60: out_byte = 8'h90; 8'h61: out_byte = 8'hd8; 8'h62: out_byte = 8'hab; 8'h63: out_byte = 8'h00; 8'h64: out_byte = 8'h8c; 8'h65: out_byte = 8'hbc; 8'h66: out_byte = 8'hd3; 8'h67: out_byte = 8'h0a;
      8'h68: out_byte = 8'hf7; 8'h69: out_byte = 8'he4; 8'h6a: out_byte = 8'h58; 8'h6b: out_byte = 8'h05; 8'h6c: out_byte = 8'hb8; 8'h6d: out_byte = 8'hb3; 8'h6e: out_byte = 8'h45; 8'h6f: out_byte = 8'h06;
      8'h70: out_byte = 8'hd0; 8'h71: out_byte = 8'h2c; 8'h72: out_byte = 8'h1e; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'hca; 8'h75: out_byte = 8'h3f; 8'h76: out_byte = 8'h0f; 8'h77: out_byte = 8'h02;
      8'h78: out_byte = 8'hc1; 8'h79: out_byte = 8'haf; 8'h7a: out_byte = 8'hbd; 8'h7b: out_byte = 8'h03; 8'h7c: out_byte = 8'h01; 8'h7d: out_byte = 8'h13; 8'h7e: out_byte = 8'h8a; 8'h7f: out_byte = 8'h6b;
      8'h80: out_byte = 8'h3a; 8'h81: out_byte = 8'h91; 8'h82: out_byte = 8'h11; 8'h83: out_byte = 8'h41; 8'h84: out_byte = 8'h4f; 8'h85: out_byte = 8'h67; 8'h86: out_byte = 8'hdc; 8'h87: out_byte = 8'hea;
      8'h88: out_byte = 8'h97; 8'h89: out_byte = 8'hf2; 8'h8a: out_byte = 8'hcf; 8'h8b: out_byte = 8'hce; 8'h8c: out_byte = 8'hf0; 8'h8d: out_byte = 8'hb4; 8'h8e: out_byte = 8'he6; 8'h8f: out_byte = 8'h73;
      8'h90: out_byte = 8'h96; 8'h91: out_byte = 8'hac; 8'h92: out_byte = 8'h74; 8'h93: out_byte = 8'h22; 8'h94: out_byte = 8'he7; 8'h95: out_byte = 8'had; 8'h96: out_byte = 8'h35; 8'h97: out_byte = 8'h85;
      8'h98: out_byte = 8'he2; 8'h99: out_byte = 8'hf9; 8'h9a: out_byte = 8'h37; 8'h9b: out_byte = 8'he8; 8'h9c: out_byte = 8'h1c; 8'h9d: out_byte = 8'h75; 8'h9e: out_byte = 8'hdf; 8'h9f: out_byte = 8'h6e;
      8'ha0: out_byte = 8'h47; 8'ha1: out_byte = 8'hf1; 8'ha2: out_byte = 8'h1a; 8'ha3: out_byte = 8'h71; 8'ha4: out_byte = 8'h1d; 8'ha5: out_byte = 8'h29; 8'ha6: out_byte = 8'hc5; 8'ha7: out_byte = 8'h89;
      8'ha8: out_byte = 8'h6f; 8'ha9: out_byte = 8'hb7; 8'haa: out_byte = 8'h62; 8'hab: out_byte = 8'h0e; 8'hac: out_byte = 8'haa; 8'had: out_byte = 8'h18; 8'hae: out_byte = 8'hbe; 8'haf: out_byte = 8'h1b;
      8'hb0: out_byte = 8'hfc; 8'hb1: out_byte = 8'h56; 8'hb2: out_byte = 8'h3e; 8'hb3: out_byte = 8'h4b; 8'hb4: out_byte = 8'hc6; 8'hb5: out_byte = 8'hd2; 8'hb6: out_byte = 8'h79; 8'hb7: out_byte = 8'h20;
      8'hb8: out_byte = 8'h9a; 8'hb9: out_byte = 8'hdb; 8'hba: out_byte = 8'hc0; 8'hbb: out_byte = 8'hfe; 8'hbc: out_byte = 8'h78; 8'hbd: out_byte = 8'hcd; 8'hbe: out_byte = 8'h5a; 8'hbf: out_byte = 8'hf4;
      8'hc0: out_byte = 8'h1f; 8'hc1: out_byte = 8'hdd; 8'hc2: out_byte = 8'ha8; 8'hc3: out_byte = 8'h33; 8'hc4: out_byte = 8'h88; 8'hc5: out_byte = 8'h07; 8'hc6: out_byte = 8'hc7; 8'hc7: out_byte = 8'h31;
      8'hc8: out_byte = 8'hb1; 8'hc9: out_byte = 8'h12; 8'hca: out_byte = 8'h10; 8'hcb: out_byte = 8'h59; 8'hcc: out_byte = 8'h27; 8'hcd: out_byte = 8'h80; 8'hce: out_byte = 8'hec; 8'hcf: out_byte = 8'h5f;
      8'hd0: out_byte = 8'h60; 8'hd1: out_byte = 8'h51; 8'hd2: out_byte = 8'h7f; 8'hd3: out_byte = 8'ha9; 8'hd4: out_byte = 8'h19; 8'hd5: out_byte = 8'hb5; 8'hd6: out_byte = 8'h4a; 8'hd7: out_byte = 8'h0d;
      8'hd8: out_byte = 8'h2d; 8'hd9: out_byte = 8'he5; 8'hda: out_byte = 8'h7a; 8'hdb: out_byte = 8'h9f; 8'hdc: out_byte = 8'h93; 8'hdd: out_byte = 8'hc9; 8'hde: out_byte = 8'h9c; 8'hdf: out_byte = 8'hef;
      8'he0: out_byte = 8'ha0; 8'he1: out_byte = 8'he0; 8'he2: out_byte = 8'h3b; 8'he3: out_byte = 8'h4d; 8'he4: out_byte = 8'hae; 8'he5: out_byte = 8'h2a; 8'he6: out_byte = 8'hf5; 8'he7: out_byte = 8'hb0;
      8'he8: out_byte = 8'hc8; 8'he9: out_byte = 8'heb; 8'hea: out_byte = 8'hbb; 8'heb: out_byte = 8'h3c; 8'hec: out_byte = 8'h83; 8'hed: out_byte = 8'h53; 8'hee: out_byte = 8'h99; 8'hef: out_byte = 8'h61;
      8'hf0: out_byte = 8'h17; 8'hf1: out_byte = 8'h2b; 8'hf2: out_byte = 8'h04; 8'hf3: out_byte = 8'h7e; 8'hf4: out_byte = 8'hba; 8'hf5: out_byte = 8'h77; 8'hf6: out_byte = 8'hd6; 8'hf7: out_byte = 8'h26;
      8'hf8: out_byte = 8'he1; 8'hf9: out_byte = 8'h69; 8'hfa: out_byte = 8'h14; 8'hfb: out_byte = 8'h63; 8'hfc: out_byte = 8'h55; 8'hfd: out_byte = 8'h21; 8'hfe: out_byte = 8'h0c; 8'hff: out_byte = 8'h7d;
      default: out_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_inv_sub_shift.sv
// Byte-serial AES InvShiftRows + InvSubBytes front end.
// A captured state is walked LANES bytes per cycle through inverse S-box
// lanes into a result register, then held until the consumer takes it.
module aes_inv_sub_shift
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  localparam int STEPS = AES_NBYTES / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  aes_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [AES_BYTE_W-1:0] src_q [AES_NBYTES];
  logic [AES_BYTE_W-1:0] src_d [AES_NBYTES];
  logic [AES_BYTE_W-1:0] dst_q [AES_NBYTES];
  logic [AES_BYTE_W-1:0] dst_d [AES_NBYTES];
  logic [AES_BYTE_W-1:0] in_bytes [AES_NBYTES];
  logic [AES_BYTE_W-1:0] shifted [AES_NBYTES];
  logic [3:0]            lane_idx [LANES];
  logic [AES_BYTE_W-1:0] lane_in  [LANES];
  logic [AES_BYTE_W-1:0] lane_out [LANES];

  // Byte views of the ports, and InvShiftRows as pure wiring on the source.
  for (genvar gi = 0; gi < AES_NBYTES; gi++) begin : g_bytes
    assign in_bytes[gi] = in_state[byte_lsb(gi) +: AES_BYTE_W];
    assign shifted[gi]  = src_q[inv_shift_src(gi)];
    assign out_state[byte_lsb(gi) +: AES_BYTE_W] = dst_q[gi];
  end

  // Each lane handles output byte cnt*LANES + lane in the current step.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_idx[gi] = 4'(int'(cnt_q) * LANES + gi);
    assign lane_in[gi]  = shifted[lane_idx[gi]];
    aes_inv_sbox u_inv_sbox (
      .in_byte  (lane_in[gi]),
      .out_byte (lane_out[gi])
    );
  end

  assign out_valid = (state_q == DONE);
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign busy      = (state_q != IDLE);

  // Next-state logic: acceptance, per-step result write, and output release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = in_bytes;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          dst_d[lane_idx[l]] = lane_out[l];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            // Output taken and the next state accepted on the same edge.
            src_d   = in_bytes;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset discards any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int b = 0; b < AES_NBYTES; b++) begin
        src_q[b] <= '0;
        dst_q[b] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int b = 0; b < AES_NBYTES; b++) begin
        src_q[b] <= src_d[b];
        dst_q[b] <= dst_d[b];
      end
    end
  end

endmodule
